run_detect_fsm: RTL and testbench

//  Parametrised run-length detector FSM. Flags z_o once input w_i has held the same value
//  for RUN_LEN consecutive enabled samples; polarity selected at run time by mode_i.

---
 rtl/run_det_pkg.sv | 23 ++
 rtl/run_det_cnt.sv | 32 +++
 rtl/run_detect_fsm.sv | 120 ++++++++++++
 tb/tb_run_detect_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared types and constants for the run-length detector.
package run_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN1 = 2'b01,
        S_RUN0 = 2'b10
    } state_e;

    localparam logic [1:0] MODE_ONES  = 2'b00;
    localparam logic [1:0] MODE_ZEROS = 2'b01;
    localparam logic [1:0] MODE_ANY   = 2'b10;

    // mode_i[1] set selects either polarity (covers both 10 and 11).
    function automatic logic polarity_ok(input state_e s, input logic [1:0] mode);
        case (s)
            S_RUN1:  polarity_ok = (mode == MODE_ONES)  || mode[1];
            S_RUN0:  polarity_ok = (mode == MODE_ZEROS) || mode[1];
            default: polarity_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/run_det_cnt.sv
// Saturating run counter with clear / load-1 / increment / hold controls.
module run_det_cnt #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next
);

    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (load)
            count_next = W'(1);
        else if (inc && (count != W'(MAX)))
            count_next = count + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/run_detect_fsm.sv
// Run-length detector: flags z_o after RUN_LEN equal enabled samples of w_i.
// Optional detection counter enabled by defining RUN_DET_HIT_CNT_EN.
module run_detect_fsm
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = $clog2(RUN_LEN + 1),
    parameter int HIT_W   = 8
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             w_i,
    input  logic [1:0]       mode_i,
    output logic             z_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] run_len_o,
    output logic [HIT_W-1:0] hit_cnt_o
);

    state_e           state, state_next;
    logic             cnt_clr, cnt_load, cnt_inc;
    logic [CNT_W-1:0] run_len, run_len_next;
    logic             z, z_next;

    run_det_cnt #(
        .W   (CNT_W),
        .MAX (RUN_LEN)
    ) u_cnt (
        .clk        (clk_i),
        .rst        (res_i),
        .clr        (cnt_clr),
        .load       (cnt_load),
        .inc        (cnt_inc),
        .count      (run_len),
        .count_next (run_len_next)
    );

    always_ff @(posedge clk_i) begin
        if (res_i)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        if (clr_i) begin
            state_next = S_IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en_i) begin
                        state_next = w_i ? S_RUN1 : S_RUN0;
                        cnt_load   = 1'b1;
                    end
                end
                S_RUN1: begin
                    if (en_i) begin
                        state_next = w_i ? S_RUN1 : S_RUN0;
                        cnt_inc    = w_i;
                        cnt_load   = !w_i;
                    end
                end
                S_RUN0: begin
                    if (en_i) begin
                        state_next = w_i ? S_RUN1 : S_RUN0;
                        cnt_inc    = !w_i;
                        cnt_load   = w_i;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    // Kept apart from the next-state block: it depends on the counter's look-ahead.
    always_comb begin
        z_next = z;
        if (clr_i || !(state inside {S_IDLE, S_RUN1, S_RUN0}))
            z_next = 1'b0;
        else if (en_i)
            z_next = (run_len_next == CNT_W'(RUN_LEN)) && polarity_ok(state_next, mode_i);
    end

    always_ff @(posedge clk_i) begin
        if (res_i)
            z <= 1'b0;
        else
            z <= z_next;
    end

`ifdef RUN_DET_HIT_CNT_EN
    logic [HIT_W-1:0] hits;

    always_ff @(posedge clk_i) begin
        if (res_i)
            hits <= '0;
        else if (!z && z_next && (hits != '1))
            hits <= hits + HIT_W'(1);
    end

    assign hit_cnt_o = hits;
`else
    assign hit_cnt_o = '0;
`endif

    assign z_o       = z;
    assign state_o   = state;
    assign run_len_o = run_len;

endmodule

// File: tb/tb_run_detect_fsm.sv
// Scoreboard bench for run_detect_fsm (RUN_LEN=4 directed + RUN_LEN=2/7 random sweep).
module tb_run_detect_fsm;
    import run_det_pkg::*;

    localparam int HIT_W = 8;

    logic       clk = 1'b0;
    logic       res = 1'b1, en = 1'b0, clr = 1'b0, w = 1'b0;
    logic [1:0] mode = 2'b00;

    logic             z4, z2, z7;
    logic [1:0]       st4, st2, st7;
    logic [2:0]       len4, len7;
    logic [1:0]       len2;
    logic [HIT_W-1:0] hit4, hit2, hit7;

    run_detect_fsm #(.RUN_LEN(4), .HIT_W(HIT_W)) u_dut4 (
        .clk_i(clk), .res_i(res), .en_i(en), .clr_i(clr), .w_i(w), .mode_i(mode),
        .z_o(z4), .state_o(st4), .run_len_o(len4), .hit_cnt_o(hit4));
    run_detect_fsm #(.RUN_LEN(2), .HIT_W(HIT_W)) u_dut2 (
        .clk_i(clk), .res_i(res), .en_i(en), .clr_i(clr), .w_i(w), .mode_i(mode),
        .z_o(z2), .state_o(st2), .run_len_o(len2), .hit_cnt_o(hit2));
    run_detect_fsm #(.RUN_LEN(7), .HIT_W(HIT_W)) u_dut7 (
        .clk_i(clk), .res_i(res), .en_i(en), .clr_i(clr), .w_i(w), .mode_i(mode),
        .z_o(z7), .state_o(st7), .run_len_o(len7), .hit_cnt_o(hit7));

    always #5 clk = ~clk;

    typedef struct {
        logic z4;
        int   st4;
        int   len4;
        int   hit4;
        logic z2;
        logic z7;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model of the RUN_LEN=4 instance (state, run length, flag, hits).
    int   m_st = 0, m_len = 0, m_hits = 0;
    logic m_z = 1'b0;
    // Independent history models for the RUN_LEN=2 / RUN_LEN=7 instances.
    logic [7:0] h2 = '0, h7 = '0;
    int   c2 = 0, c7 = 0;
    logic mz2 = 1'b0, mz7 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic mode_allows(input logic v, input logic [1:0] md);
        return md[1] || (v ? (md == 2'b00) : (md == 2'b01));
    endfunction

    function automatic logic hist_z(input logic [7:0] h, input int c, input int l,
                                    input logic v, input logic [1:0] md);
        logic same = 1'b1;
        for (int i = 0; i < l; i++)
            if (h[i] != v) same = 1'b0;
        return (c >= l) && same && mode_allows(v, md);
    endfunction

    task automatic model_step();
        logic nz;
        if (res) begin
            m_st = 0; m_len = 0; m_z = 1'b0; m_hits = 0;
        end else if (clr) begin
            m_st = 0; m_len = 0; m_z = 1'b0;
        end else if (en) begin
            if (w) begin
                m_len = (m_st == 1) ? ((m_len < 4) ? m_len + 1 : 4) : 1;
                m_st  = 1;
            end else begin
                m_len = (m_st == 2) ? ((m_len < 4) ? m_len + 1 : 4) : 1;
                m_st  = 2;
            end
            nz = (m_len == 4) && mode_allows(w, mode);
            if (!m_z && nz && m_hits < (1 << HIT_W) - 1) m_hits++;
            m_z = nz;
        end
        if (res || clr) begin
            h2 = '0; h7 = '0; c2 = 0; c7 = 0; mz2 = 1'b0; mz7 = 1'b0;
        end else if (en) begin
            h2 = {h2[6:0], w}; h7 = {h7[6:0], w};
            if (c2 < 2) c2++;
            if (c7 < 7) c7++;
            mz2 = hist_z(h2, c2, 2, w, mode);
            mz7 = hist_z(h7, c7, 7, w, mode);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic e, input logic wi,
                        input logic [1:0] md);
        exp_t ex;
        @(negedge clk);
        res = r; clr = c; en = e; w = wi; mode = md;
        model_step();
        ex.z4 = m_z; ex.st4 = m_st; ex.len4 = m_len;
`ifdef RUN_DET_HIT_CNT_EN
        ex.hit4 = m_hits;
`else
        ex.hit4 = 0;
`endif
        ex.z2 = mz2; ex.z7 = mz7;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            ex = exp_q.pop_front();
            check("z4", 32'(z4), 32'(ex.z4));
            check("state4", 32'(st4), 32'(ex.st4));
            check("run_len4", 32'(len4), 32'(ex.len4));
            check("hit_cnt4", 32'(hit4), 32'(ex.hit4));
            check("z2", 32'(z2), 32'(ex.z2));
            check("z7", 32'(z7), 32'(ex.z7));
        end
    endtask

    task automatic samples(input int n, input logic wi, input logic [1:0] md);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, wi, md);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        check("reset_state_idle", 32'(st4), 32'(S_IDLE));

        // Runs of 1 with overlap, then opposite value
        samples(5, 1'b1, MODE_ONES);
        samples(1, 1'b0, MODE_ONES);
        check("run0_after_ones", 32'(st4), 32'(S_RUN0));

        // Polarity modes
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        samples(4, 1'b0, MODE_ZEROS);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        samples(4, 1'b0, MODE_ONES);
        samples(4, 1'b1, MODE_ANY);
        samples(4, 1'b0, MODE_ANY);
        samples(3, 1'b0, 2'b11);

        // Mid-run mode change reuses the accumulated length
        samples(2, 1'b1, MODE_ZEROS);
        samples(2, 1'b1, MODE_ONES);

        // Enable gaps do not break a run
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        samples(2, 1'b1, MODE_ONES);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, MODE_ONES);
        samples(2, 1'b1, MODE_ONES);
        check("gap_run_detect", 32'(z4), 32'd1);

        // Soft clear at run length 3, then rebuild
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        samples(3, 1'b1, MODE_ONES);
        step(1'b0, 1'b1, 1'b1, 1'b1, MODE_ONES);
        samples(4, 1'b1, MODE_ONES);

        // Reset mid-run
        samples(2, 1'b0, MODE_ANY);
        step(1'b1, 1'b0, 1'b1, 1'b0, MODE_ANY);
        check("reset_midrun_len", 32'(len4), 32'd0);

        // Repeated separate runs exercise the detection counter
        for (int k = 0; k < 5; k++) begin
            samples(4, 1'b1, MODE_ONES);
            samples(1, 1'b0, MODE_ONES);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, MODE_ONES);

        // Random sweep across all three depths
        for (int i = 0; i < 4000; i++) begin
            int unsigned rr = $urandom_range(0, 199);
            int unsigned rc = $urandom_range(0, 99);
            step(rr == 0, rc < 3, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
